// File: rtl/joy_spi_if.sv
// Pin-level bundle between the PmodJSTK SPI reader and its surroundings:
// the SPI wires plus the decoded joystick position/button outputs.
interface joy_spi_if;
    logic [1:0] leds;
    logic       miso;
    logic       ss_n;
    logic       sclk;
    logic       mosi;
    logic [9:0] joy_x;
    logic [9:0] joy_y;
    logic [2:0] buttons;
    logic       data_valid;

    modport master (
        input  leds, miso,
        output ss_n, sclk, mosi, joy_x, joy_y, buttons, data_valid
    );

    modport slave (
        output leds, miso,
        input  ss_n, sclk, mosi, joy_x, joy_y, buttons, data_valid
    );
endinterface

// File: rtl/joy_spi_reader.sv
// Periodic PmodJSTK poller: runs a 5-byte SPI mode-0 exchange and publishes
// joystick X/Y and buttons atomically with a one-cycle data_valid pulse.
module joy_spi_reader #(
    parameter int unsigned HALF_DIV = 100,
    parameter int unsigned SS_SETUP = 1500,
    parameter int unsigned BYTE_GAP = 1000,
    parameter int unsigned POLL_DIV = 1000000
) (
    input  logic      clk,
    input  logic      clr,
    joy_spi_if.master bus
);

    localparam int unsigned MAX_A   = (HALF_DIV > SS_SETUP) ? HALF_DIV : SS_SETUP;
    localparam int unsigned MAX_B   = (BYTE_GAP > POLL_DIV) ? BYTE_GAP : POLL_DIV;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             half_q, half_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;

    logic [1:0]       leds_q;
    logic [6:0]       rx_sh_q;
    logic [7:0]       x_lo_q, y_lo_q;
    logic [1:0]       x_hi_q, y_hi_q;
    logic [2:0]       btn_q;

    logic             ss_n_q, sclk_q, mosi_q, dv_q;
    logic             ss_n_d, sclk_d, mosi_d, dv_d;
    logic [9:0]       joy_x_q, joy_y_q;
    logic [2:0]       buttons_q;

    logic             phase_end_c, rise_c;
    logic [7:0]       tx_byte_c, rx_byte_c;

    assign phase_end_c = (cnt_q == CNT_W'(HALF_DIV - 1));
    // This edge ends a low half-period, so sclk rises and miso is captured now.
    assign rise_c      = (state_q == SHIFT) && !half_q && phase_end_c;
    assign rx_byte_c   = {rx_sh_q, bus.miso};

    // State register with capture and result datapath.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            half_q    <= 1'b0;
            bit_q     <= '0;
            byte_q    <= '0;
            leds_q    <= '0;
            rx_sh_q   <= '0;
            x_lo_q    <= '0;
            x_hi_q    <= '0;
            y_lo_q    <= '0;
            y_hi_q    <= '0;
            btn_q     <= '0;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dv_q      <= 1'b0;
            joy_x_q   <= 10'd512;
            joy_y_q   <= 10'd512;
            buttons_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            dv_q    <= dv_d;

            if (state_q == IDLE && state_d == SETUP) begin
                leds_q <= bus.leds;
            end

            if (rise_c) begin
                rx_sh_q <= rx_byte_c[6:0];
                if (bit_q == 3'd7) begin
                    case (byte_q)
                        3'd0:    x_lo_q <= rx_byte_c;
                        3'd1:    x_hi_q <= rx_byte_c[1:0];
                        3'd2:    y_lo_q <= rx_byte_c;
                        3'd3:    y_hi_q <= rx_byte_c[1:0];
                        default: btn_q  <= rx_byte_c[2:0];
                    endcase
                end
            end

            // Publish all fields together, only from a completed exchange.
            if (state_d == DONE) begin
                joy_x_q   <= {x_hi_q, x_lo_q};
                joy_y_q   <= {y_hi_q, y_lo_q};
                buttons_q <= btn_q;
            end
        end
    end

    // Next-state and sequencing counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        half_d  = half_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: begin
                if (cnt_q == CNT_W'(POLL_DIV - 1)) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    byte_d  = '0;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SS_SETUP - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (phase_end_c) begin
                    cnt_d  = '0;
                    half_d = ~half_q;
                    if (half_q) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (byte_q == 3'd4) begin
                                state_d = DONE;
                            end else begin
                                state_d = GAP;
                                byte_d  = byte_q + 3'd1;
                            end
                        end
                    end
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(BYTE_GAP - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state, so pins change on the same edge as the state.
    always_comb begin
        ss_n_d    = 1'b1;
        sclk_d    = 1'b0;
        mosi_d    = 1'b0;
        dv_d      = 1'b0;
        tx_byte_c = (byte_d == 3'd0) ? {6'b100000, leds_q} : 8'h00;
        case (state_d)
            SETUP, GAP: ss_n_d = 1'b0;
            SHIFT: begin
                ss_n_d = 1'b0;
                sclk_d = half_d;
                mosi_d = tx_byte_c[3'd7 - bit_d];
            end
            DONE:    dv_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.ss_n       = ss_n_q;
    assign bus.sclk       = sclk_q;
    assign bus.mosi       = mosi_q;
    assign bus.data_valid = dv_q;
    assign bus.joy_x      = joy_x_q;
    assign bus.joy_y      = joy_y_q;
    assign bus.buttons    = buttons_q;

endmodule
